// File: rtl/uart_tx_scheduler.sv
// Frame scheduler between the register block and the UART TX engine.
// Buffers bytes in a FIFO and launches one frame per byte, with config frozen per frame.
module uart_tx_scheduler #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic                     wr_valid_i,
  input  logic [7:0]               wr_data_i,
  output logic                     wr_ready_o,
  input  logic [1:0]               cfg_data_bit_num_i,
  input  logic                     cfg_stop_bit_num_i,
  input  logic                     cfg_parity_en_i,
  input  logic                     cfg_parity_type_i,
  input  logic                     tx_done_i,
  output logic                     start_tx_o,
  output logic [7:0]               tx_data_o,
  output logic [1:0]               data_bit_num_o,
  output logic                     stop_bit_num_o,
  output logic                     parity_en_o,
  output logic                     parity_type_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     overflow_o,
  output logic                     timeout_o,
  input  logic                     clr_status_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  // state | meaning
  // IDLE  | waiting for enable and a queued byte; pops head on exit
  // LOAD  | latch popped byte and live config into frame outputs
  // START | start_tx_o high for this single cycle; arm timeout timer
  // WAIT  | waiting for tx_done_i or timer terminal count
  // GAP   | inter-frame idle cycles before returning to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            r_wr_ready;
  logic [7:0]      r_head;
  logic [TW-1:0]   r_tmr;
  logic [GW-1:0]   r_gap;
  logic            r_start;
  logic [7:0]      r_tx_data;
  logic [1:0]      r_dbn;
  logic            r_sbn;
  logic            r_pen;
  logic            r_pty;
  logic            r_busy;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_push;
  logic            w_pop;
  logic            w_to_hit;
  logic [AW:0]     w_level_nxt;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_push   = wr_valid_i & r_wr_ready;
  assign w_pop    = (r_state == S_IDLE) & enable_i & (r_level != '0);
  assign w_to_hit = (r_state == S_WAIT) & ~tx_done_i & (r_tmr == '0);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wr_ready <= 1'b1;
      r_head     <= '0;
      r_tmr      <= '0;
      r_gap      <= '0;
      r_start    <= 1'b0;
      r_tx_data  <= '0;
      r_dbn      <= '0;
      r_sbn      <= 1'b0;
      r_pen      <= 1'b0;
      r_pty      <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_level    <= w_level_nxt;
      r_wr_ready <= (w_level_nxt != FULL_LVL);
      r_start    <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_head   <= r_mem[r_rd_ptr];
      end

      if (wr_valid_i && !r_wr_ready) begin
        r_overflow <= 1'b1;
      end else if (clr_status_i) begin
        r_overflow <= 1'b0;
      end

      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end else if (clr_status_i) begin
        r_timeout <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_tx_data <= r_head;
          r_dbn     <= cfg_data_bit_num_i;
          r_sbn     <= cfg_stop_bit_num_i;
          r_pen     <= cfg_parity_en_i;
          r_pty     <= cfg_parity_type_i;
          r_start   <= 1'b1;
          r_state   <= S_START;
        end
        S_START: begin
          r_tmr   <= TMR_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_i) begin
            if (GAP_CYCLES > 0) begin
              r_gap   <= GAP_LOAD;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_tmr == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - TMR_ONE;
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - GAP_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready_o     = r_wr_ready;
  assign start_tx_o     = r_start;
  assign tx_data_o      = r_tx_data;
  assign data_bit_num_o = r_dbn;
  assign stop_bit_num_o = r_sbn;
  assign parity_en_o    = r_pen;
  assign parity_type_o  = r_pty;
  assign busy_o         = r_busy;
  assign fifo_level_o   = r_level;
  assign overflow_o     = r_overflow;
  assign timeout_o      = r_timeout;

endmodule
